// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and lock-state encoding, used by receiver and generator.
package vga_timing_pkg;

  localparam int unsigned VgaHSync   = 40;
  localparam int unsigned VgaHBack   = 128;
  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHTotal  = 832;
  localparam int unsigned VgaVSync   = 3;
  localparam int unsigned VgaVBack   = 28;
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVTotal  = 520;
  localparam bit          VgaSyncPol = 1'b0;

  localparam logic [9:0] CntMax = 10'd1023;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers the raw video inputs, runs the line/frame counters and decides whether
// the incoming timing is stable enough to trust (lock FSM plus error counter).
module vga_sync_tracker
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = VgaHTotal,
  parameter int unsigned V_TOTAL  = VgaVTotal,
  parameter bit          SYNC_POL = VgaSyncPol
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       bw,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       pix_bw,
  output logic       v_edge,
  output logic       err,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic [9:0] HLast = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast = 10'(V_TOTAL - 1);

  logic hs_q, vs_q, hs_prev, vs_prev;
  logic h_edge, line_err, frame_err;
  sync_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      hs_prev <= ~SYNC_POL;
      vs_prev <= ~SYNC_POL;
      pix_bw  <= 1'b0;
    end else begin
      hs_q    <= hsync;
      vs_q    <= vsync;
      pix_bw  <= bw;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
    end
  end

  assign h_edge = (hs_q == SYNC_POL) && (hs_prev != SYNC_POL);
  assign v_edge = (vs_q == SYNC_POL) && (vs_prev != SYNC_POL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_edge) begin
        h_cnt <= '0;
      end else if (h_cnt != CntMax) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (v_edge) begin
        v_cnt <= '0;
      end else if (h_edge && (v_cnt != CntMax)) begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  // A line start after the last line with no vsync edge means vsync went missing.
  assign line_err  = (h_edge && (h_cnt != HLast)) || (h_cnt == CntMax);
  assign frame_err = v_edge ? (v_cnt != VLast) : (h_edge && (v_cnt == VLast));
  assign err       = line_err || frame_err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StSearch:  if (v_edge) state_d = StAcquire;
      StAcquire: begin
        if (err) begin
          state_d = StSearch;
        end else if (v_edge) begin
          state_d = StLocked;
        end
      end
      StLocked:  if (err) state_d = StSearch;
      default:   state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StSearch;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StLocked) && err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign locked = (state_q == StLocked);

endmodule

// File: rtl/classic_vga_receiver.sv
// VGA receiver: tracks sync timing, presents active-area pixels with coordinates and
// captures a 16x16 monochrome window of one frame into a row-readable buffer.
module classic_vga_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = VgaHSync,
  parameter int unsigned H_BACK   = VgaHBack,
  parameter int unsigned H_ACTIVE = VgaHActive,
  parameter int unsigned H_TOTAL  = VgaHTotal,
  parameter int unsigned V_SYNC   = VgaVSync,
  parameter int unsigned V_BACK   = VgaVBack,
  parameter int unsigned V_ACTIVE = VgaVActive,
  parameter int unsigned V_TOTAL  = VgaVTotal,
  parameter bit          SYNC_POL = VgaSyncPol
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_horizSync,
  input  logic        vga_vertSync,
  input  logic        black_white,
  input  logic [9:0]  win_x,
  input  logic [9:0]  win_y,
  input  logic        capture_req,
  input  logic [3:0]  rd_row,
  output logic [15:0] rd_data,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        pixel_valid,
  output logic        pixel_out,
  output logic        locked,
  output logic        frame_start,
  output logic [7:0]  err_count,
  output logic        capture_busy,
  output logic        capture_done,
  output logic        capture_abort
);

  localparam logic [9:0]  HOff   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  VOff   = 10'(V_SYNC + V_BACK);
  localparam logic [10:0] HStart = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HEnd   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] VStart = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VEnd   = 11'(V_SYNC + V_BACK + V_ACTIVE);

  logic [9:0] h_cnt, v_cnt;
  logic       pix_bw, v_edge, err;
  logic       active, show;

  vga_sync_tracker #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .SYNC_POL(SYNC_POL)
  ) u_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .hsync    (vga_horizSync),
    .vsync    (vga_vertSync),
    .bw       (black_white),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .pix_bw   (pix_bw),
    .v_edge   (v_edge),
    .err      (err),
    .locked   (locked),
    .err_count(err_count)
  );

  assign active = ({1'b0, h_cnt} >= HStart) && ({1'b0, h_cnt} < HEnd) &&
                  ({1'b0, v_cnt} >= VStart) && ({1'b0, v_cnt} < VEnd);
  assign show   = locked && active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0;
      pixel_out   <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= show;
      pixel_out   <= show ? pix_bw : 1'b0;
      x_pos       <= show ? h_cnt - HOff : '0;
      y_pos       <= show ? v_cnt - VOff : '0;
      frame_start <= show && (h_cnt == HOff) && (v_cnt == VOff);
    end
  end

  // Capture window, evaluated on the presented (output-stage) pixel stream.
  logic        capturing_q;
  logic [10:0] col_off, row_off;
  logic        in_win, store, accept, finish, abort;
  logic [15:0] cap_buf [16];

  assign col_off = {1'b0, x_pos} - {1'b0, win_x};
  assign row_off = {1'b0, y_pos} - {1'b0, win_y};
  assign in_win  = pixel_valid && (col_off < 11'd16) && (row_off < 11'd16);
  assign store   = capture_busy && (capturing_q || frame_start) && in_win;
  assign accept  = capture_req && locked && !capture_busy;
  assign finish  = capture_busy && capturing_q && v_edge && !err;
  assign abort   = capture_busy && !locked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_busy  <= 1'b0;
      capturing_q   <= 1'b0;
      capture_done  <= 1'b0;
      capture_abort <= 1'b0;
    end else begin
      capture_done  <= 1'b0;
      capture_abort <= 1'b0;
      if (abort) begin
        capture_busy  <= 1'b0;
        capturing_q   <= 1'b0;
        capture_abort <= 1'b1;
      end else if (finish) begin
        capture_busy <= 1'b0;
        capturing_q  <= 1'b0;
        capture_done <= 1'b1;
      end else if (accept) begin
        capture_busy <= 1'b1;
      end else if (capture_busy && frame_start) begin
        capturing_q <= 1'b1;
      end
    end
  end

  // Buffer is wiped on accept so window pixels outside the active area read as 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        cap_buf[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 16; i++) begin
          cap_buf[i] <= '0;
        end
      end else if (store) begin
        cap_buf[row_off[3:0]][4'd15 - col_off[3:0]] <= pixel_out;
      end
      rd_data <= cap_buf[rd_row];
    end
  end

endmodule

// File: tb/tb_classic_vga_receiver.sv
// Directed bench for classic_vga_receiver on a scaled-down video timing.
module tb_classic_vga_receiver;

  localparam int H_SYNC = 4, H_BACK = 4, H_ACTIVE = 32, H_TOTAL = 44;
  localparam int V_SYNC = 2, V_BACK = 2, V_ACTIVE = 24, V_TOTAL = 30;
  localparam bit SyncPol = 1'b0;
  localparam int HOff = H_SYNC + H_BACK;
  localparam int VOff = V_SYNC + V_BACK;
  localparam int FrameClks = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vga_horizSync, vga_vertSync, black_white;
  logic [9:0]  win_x, win_y;
  logic        capture_req;
  logic [3:0]  rd_row;
  logic [15:0] rd_data;
  logic [9:0]  x_pos, y_pos;
  logic        pixel_valid, pixel_out, locked, frame_start;
  logic [7:0]  err_count;
  logic        capture_busy, capture_done, capture_abort;

  int checks = 0;
  int errors = 0;
  int cur_vp = 0, cur_hp = 0;
  int short_vp = -1;
  bit no_vsync = 1'b0;
  int mode = 0;

  always #5 clk = ~clk;

  classic_vga_receiver #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .SYNC_POL(SyncPol)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vga_horizSync(vga_horizSync),
    .vga_vertSync (vga_vertSync),
    .black_white  (black_white),
    .win_x        (win_x),
    .win_y        (win_y),
    .capture_req  (capture_req),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .pixel_valid  (pixel_valid),
    .pixel_out    (pixel_out),
    .locked       (locked),
    .frame_start  (frame_start),
    .err_count    (err_count),
    .capture_busy (capture_busy),
    .capture_done (capture_done),
    .capture_abort(capture_abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The receiver's h counter restarts one clock after the first sync clock, so the
  // pixel driven at line position hp is presented as x = hp - HOff - 1.
  task automatic step();
    int x, y;
    vga_horizSync = (cur_hp < H_SYNC) ? SyncPol : ~SyncPol;
    vga_vertSync  = ((cur_vp < V_SYNC) && !no_vsync) ? SyncPol : ~SyncPol;
    x = cur_hp - HOff - 1;
    y = cur_vp - VOff;
    if (x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE) begin
      black_white = (mode == 0) ? (x == 10 && y == 5) : (((x + y) % 2) == 0);
    end else begin
      black_white = 1'b1;
    end
    @(posedge clk);
    #1;
    if (cur_hp == H_TOTAL - 1 || (cur_vp == short_vp && cur_hp == H_TOTAL - 2)) begin
      cur_hp = 0;
      cur_vp = (cur_vp == V_TOTAL - 1) ? 0 : cur_vp + 1;
    end else begin
      cur_hp++;
    end
  endtask

  task automatic run_to(input int v, input int h);
    int n = 0;
    while (!(cur_vp == v && cur_hp == h) && n < 2 * FrameClks) begin
      step();
      n++;
    end
    if (!(cur_vp == v && cur_hp == h)) begin
      checks++;
      errors++;
      $error("FAIL run_to: reached %0d,%0d required %0d,%0d", cur_vp, cur_hp, v, h);
    end
  endtask

  task automatic run_past(input int v, input int h);
    run_to(v, h);
    step();
  endtask

  task automatic pulse_capture();
    capture_req = 1'b1;
    step();
    capture_req = 1'b0;
  endtask

  task automatic read_row(input logic [3:0] r, input logic [15:0] exp, input string tag);
    rd_row = r;
    step();
    check(tag, rd_data, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    vga_horizSync = ~SyncPol;
    vga_vertSync  = ~SyncPol;
    black_white = 1'b0;
    win_x = '0;
    win_y = '0;
    capture_req = 1'b0;
    rd_row = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_err", err_count, 0);
    check("rst_busy", capture_busy, 0);
    check("rst_rd", rd_data, 0);
    check("rst_fs", frame_start, 0);
    reset_n = 1'b1;

    // Frame 0: acquiring, capture requests must be ignored.
    run_to(10, 0);
    pulse_capture();
    check("req_unlocked", capture_busy, 0);

    // Frame 1: lock on the second vsync edge.
    run_to(0, 0);
    run_past(0, 0);
    check("pre_lock", locked, 0);
    step();
    check("lock", locked, 1);
    check("lock_err", err_count, 0);
    run_past(4, 10);
    check("fs_pulse", frame_start, 1);
    check("fs_x", x_pos, 0);
    step();
    check("fs_end", frame_start, 0);
    run_past(9, 2);
    check("blank_valid", pixel_valid, 0);
    check("blank_pix", pixel_out, 0);
    check("blank_x", x_pos, 0);
    run_past(9, 19);
    check("px9_x", x_pos, 9);
    check("px9_pix", pixel_out, 0);
    step();
    check("px10_valid", pixel_valid, 1);
    check("px10_x", x_pos, 10);
    check("px10_y", y_pos, 5);
    check("px10_pix", pixel_out, 1);

    // Window fully inside the active area, checkerboard captured in frame 2.
    mode = 1;
    win_x = 10'd4;
    win_y = 10'd2;
    run_to(15, 0);
    pulse_capture();
    check("cap1_busy", capture_busy, 1);
    run_to(0, 0);
    run_past(0, 0);
    step();
    check("cap1_wait_busy", capture_busy, 1);
    check("cap1_wait_done", capture_done, 0);
    run_to(0, 0);
    run_past(0, 0);
    step();
    check("cap1_done", capture_done, 1);
    check("cap1_idle", capture_busy, 0);
    step();
    check("cap1_done_end", capture_done, 0);
    read_row(4'd0, 16'hAAAA, "cap1_row0");
    read_row(4'd1, 16'h5555, "cap1_row1");
    read_row(4'd15, 16'h5555, "cap1_row15");

    // Window straddling the right and bottom edges of the active area.
    win_x = 10'd24;
    win_y = 10'd18;
    run_to(15, 0);
    pulse_capture();
    run_to(0, 0);
    run_past(0, 0);
    run_to(0, 0);
    run_past(0, 0);
    step();
    check("cap2_done", capture_done, 1);
    read_row(4'd0, 16'hAA00, "cap2_row0");
    read_row(4'd1, 16'h5500, "cap2_row1");
    read_row(4'd5, 16'h5500, "cap2_row5");
    read_row(4'd6, 16'h0000, "cap2_row6");
    read_row(4'd15, 16'h0000, "cap2_row15");

    // One line a clock short drops lock and counts one error.
    short_vp = 20;
    run_past(21, 0);
    check("short_pre_lock", locked, 1);
    check("short_pre_err", err_count, 0);
    step();
    check("short_unlock", locked, 0);
    check("short_err", err_count, 1);
    short_vp = -1;
    run_to(0, 0);
    run_past(0, 0);
    step();
    check("relock_acq", locked, 0);
    run_past(9, 20);
    check("acq_valid", pixel_valid, 0);
    check("acq_pix", pixel_out, 0);
    run_to(0, 0);
    run_past(0, 0);
    step();
    check("relock", locked, 1);
    check("relock_err", err_count, 1);

    // Vsync disappears while a capture is in progress.
    win_x = 10'd4;
    win_y = 10'd2;
    run_to(15, 0);
    pulse_capture();
    check("cap3_busy", capture_busy, 1);
    run_to(0, 0);
    run_past(0, 0);
    run_to(0, 0);
    no_vsync = 1'b1;
    run_past(0, 0);
    step();
    check("nov_unlock", locked, 0);
    check("nov_err", err_count, 2);
    check("nov_busy", capture_busy, 1);
    check("nov_abort_pre", capture_abort, 0);
    step();
    check("nov_abort", capture_abort, 1);
    check("nov_idle", capture_busy, 0);
    check("nov_done", capture_done, 0);
    step();
    check("nov_abort_end", capture_abort, 0);
    no_vsync = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/classic_vga_receiver.md
CLASSIC_VGA_RECEIVER -- requirements
Module: classic_vga_receiver

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_SYNC 40 hsync width in clocks; H_BACK 128 back porch clocks; H_ACTIVE 640 visible pixels; H_TOTAL 832 clocks per line.
  V_SYNC 3 vsync width in lines; V_BACK 28 back porch lines; V_ACTIVE 480 visible lines; V_TOTAL 520 lines per frame.
  SYNC_POL 0 asserted sync level (0 = active-low).
REQ-002 Ports (name direction width meaning), clock and reset first:
  clk in 1 31.5 MHz pixel clock; reset_n in 1 reset, asynchronous, active-low.
  vga_horizSync in 1; vga_vertSync in 1; black_white in 1 pixel data.
  win_x in 10, win_y in 10 capture window origin, active coordinates.
  capture_req in 1 single-cycle capture request.
  rd_row in 4 buffer row select; rd_data out 16 row contents.
  x_pos out 10, y_pos out 10 active coordinates; pixel_valid out 1; pixel_out out 1.
  locked out 1; frame_start out 1 pulse; err_count out 8.
  capture_busy out 1; capture_done out 1 pulse; capture_abort out 1 pulse.

Function
REQ-003 All three video inputs SHALL be registered once; edge detection uses registered vs. previous registered value.
REQ-004 h_cnt SHALL load 0 on the cycle after an hsync assert edge, else increment, saturating at 1023.
REQ-005 v_cnt SHALL load 0 on vsync assert edge and increment on each hsync assert edge otherwise; coincident edges: vsync wins.
REQ-006 Line error: hsync assert edge with h_cnt != H_TOTAL-1, or h_cnt saturated; frame error: vsync assert edge with v_cnt != V_TOTAL-1.
REQ-007 State machine SEARCH, ACQUIRE, LOCKED; reset enters SEARCH.
REQ-008 SEARCH -> ACQUIRE on vsync assert edge; ACQUIRE -> LOCKED on next vsync assert edge with zero errors in that frame; any error in ACQUIRE or LOCKED -> SEARCH.
REQ-009 err_count SHALL increment by one per error cycle while in LOCKED, saturating at 255; cleared only by reset.
REQ-010 locked SHALL be 1 exactly while state is LOCKED.
REQ-011 Active region: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE.
REQ-012 pixel_valid SHALL be 1 when locked and in active region; x_pos/y_pos are counters minus their offsets, pixel_out the registered black_white, all registered (2 clocks input-to-output).
REQ-013 x_pos, y_pos, pixel_out SHALL be 0 whenever pixel_valid is 0.
REQ-014 frame_start SHALL pulse one cycle when locked and x_pos=0, y_pos=0 is presented.
REQ-015 capture_req when locked and not busy SHALL set capture_busy next cycle; ignored otherwise.
REQ-016 Busy capture SHALL begin at next frame_start, storing pixel_out at (win_x+c, win_y+r), c,r in 0..15, into row r bit 15-c.
REQ-017 Window pixels outside active area SHALL store 0.
REQ-018 Capture completes at next vsync assert edge: capture_done pulses one cycle, capture_busy clears same cycle.
REQ-019 Lock loss while busy SHALL pulse capture_abort, clear capture_busy; buffer contents then unspecified.
REQ-020 rd_data SHALL present row rd_row one clock after rd_row is applied; reads allowed at any time.

Reset
REQ-021 reset_n low SHALL asynchronously force SEARCH, counters 0, all outputs 0, capture_busy 0.
REQ-022 Capture buffer SHALL reset to all zeros.

Structure
REQ-023 Timing constants and state encoding SHALL live in shared package vga_timing_pkg, also used by the VGA generator.
REQ-024 One sub-module, vga_sync_tracker (input registers, counters, lock FSM); capture buffer stays in top.

Verification
REQ-025 Nominal 640x480@72 stream from reset -> locked=1 after second vsync assert edge, err_count=0.
REQ-026 Locked, one line of 831 clocks -> locked=0 next cycle, err_count=1, relock after two clean frames.
REQ-027 Pixel at (100,50) driven 1 -> pixel_valid=1, x_pos=100, y_pos=50, pixel_out=1 two clocks later.
REQ-028 win=(510,200), 16x16 checkerboard, capture_req -> capture_done one frame later, rd_row=0 gives 16'hAAAA.
REQ-029 win=(630,470) -> columns/rows beyond 639/479 read 0.
REQ-030 vsync removed mid-capture -> capture_abort pulse, capture_busy=0, err_count incremented.
